// File: rtl/dmem_mailbox_if.sv
// Data-memory port between the MIPS core (master) and its data memory (slave).
// Carries the store strobe, byte address, store data and combinational load data.
interface dmem_mailbox_if;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite,
    output dataaddr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  dataaddr,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/dmem_mailbox.sv
// Word RAM serving the core's loads/stores, plus a mailbox word that latches the
// program's self-check verdict (pass, fail or timeout) so an FPGA build can report it.
module dmem_mailbox #(
  parameter int unsigned DEPTH          = 64,
  parameter logic [31:0] MBOX_ADDR      = 32'd84,
  parameter logic [31:0] EXPECT         = 32'd7,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mailbox_if.slave        bus,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          store_count
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t      r_state;
  logic [31:0] r_cycles;
  logic [15:0] r_store_count;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_run;
  logic          w_mbox_hit;
  logic          w_ram_we;

  // Upper address bits are dropped for RAM indexing, but the mailbox needs an exact match.
  assign w_idx      = bus.dataaddr[AW+1:2];
  assign w_run      = (r_state == S_RUN);
  assign w_mbox_hit = bus.memwrite && (bus.dataaddr == MBOX_ADDR);
  assign w_ram_we   = bus.memwrite && w_run;

  // RAM is deliberately left out of reset so its contents survive for inspection.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= bus.writedata;
    end
  end

  assign bus.readdata = r_mem[w_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_cycles      <= 32'd0;
      r_store_count <= 16'd0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cycles <= r_cycles + 32'd1;
      if (bus.memwrite && (r_store_count != 16'hFFFF)) begin
        r_store_count <= r_store_count + 16'd1;
      end
      // A mailbox store takes priority over a timeout landing in the same cycle.
      if (w_mbox_hit) begin
        r_done <= 1'b1;
        if (bus.writedata == EXPECT) begin
          r_state <= S_PASS;
          r_pass  <= 1'b1;
        end else begin
          r_state <= S_FAIL;
        end
      end else if (r_cycles == LAST_CYCLE) begin
        r_state   <= S_TIMEOUT;
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_dmem_mailbox.sv
// Bench for dmem_mailbox: a vector table for RAM/aliasing behaviour on a default
// instance, and hand sequences for verdicts, reset and a short-timeout instance.
module tb_dmem_mailbox;

  logic clk;
  logic resetA;
  logic resetB;

  logic        doneA, passA, timeoutA;
  logic [15:0] countA;
  logic        doneB, passB, timeoutB;
  logic [15:0] countB;

  int checkCount;
  int passCount;

  dmem_mailbox_if busA ();
  dmem_mailbox_if busB ();

  dmem_mailbox dutA (
    .clk         (clk),
    .reset       (resetA),
    .bus         (busA),
    .done        (doneA),
    .pass        (passA),
    .timeout     (timeoutA),
    .store_count (countA)
  );

  dmem_mailbox #(
    .TIMEOUT_CYCLES (20)
  ) dutB (
    .clk         (clk),
    .reset       (resetB),
    .bus         (busB),
    .done        (doneB),
    .pass        (passB),
    .timeout     (timeoutB),
    .store_count (countB)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expDone;
    logic        expPass;
    logic        expTimeout;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkVec(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic chkRd,
                                 input logic [31:0] expRd, input logic [15:0] expCount);
    vec_t v;
    v.we         = we;
    v.addr       = addr;
    v.wdata      = wdata;
    v.chkRd      = chkRd;
    v.expRd      = expRd;
    v.expDone    = 1'b0;
    v.expPass    = 1'b0;
    v.expTimeout = 1'b0;
    v.expCount   = expCount;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    busA.memwrite  = we;
    busA.dataaddr  = addr;
    busA.writedata = wdata;
  endtask

  // One clock on instance A, leaving time 1 ns past the edge with the strobe dropped.
  task automatic stepA();
    @(posedge clk);
    #1;
    busA.memwrite = 1'b0;
  endtask

  task automatic checkFlagsA(input string tag, input logic d, input logic p,
                             input logic t, input logic [15:0] c);
    checkOutput({tag, "_done"},    {31'd0, doneA},    {31'd0, d});
    checkOutput({tag, "_pass"},    {31'd0, passA},    {31'd0, p});
    checkOutput({tag, "_timeout"}, {31'd0, timeoutA}, {31'd0, t});
    checkOutput({tag, "_count"},   {16'd0, countA},   {16'd0, c});
  endtask

  task automatic checkFlagsB(input string tag, input logic d, input logic p,
                             input logic t, input logic [15:0] c);
    checkOutput({tag, "_done"},    {31'd0, doneB},    {31'd0, d});
    checkOutput({tag, "_pass"},    {31'd0, passB},    {31'd0, p});
    checkOutput({tag, "_timeout"}, {31'd0, timeoutB}, {31'd0, t});
    checkOutput({tag, "_count"},   {16'd0, countB},   {16'd0, c});
  endtask

  task automatic pulseResetA();
    resetA = 1'b0;
    #1;
    resetA = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    resetA = 1'b0;
    resetB = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0);
    busB.memwrite  = 1'b0;
    busB.dataaddr  = 32'd0;
    busB.writedata = 32'd0;

    // Index 21 is the mailbox word; 340 and 260/264 alias words 21, 1 and 2.
    vecs[0] = mkVec(1'b1, 32'd0,   32'd5,         1'b0, 32'd0,         16'd1);
    vecs[1] = mkVec(1'b0, 32'd0,   32'd0,         1'b1, 32'd5,         16'd1);
    vecs[2] = mkVec(1'b1, 32'd4,   32'h12345678,  1'b0, 32'd0,         16'd2);
    vecs[3] = mkVec(1'b0, 32'd4,   32'd0,         1'b1, 32'h12345678,  16'd2);
    vecs[4] = mkVec(1'b0, 32'd6,   32'd0,         1'b1, 32'h12345678,  16'd2);
    vecs[5] = mkVec(1'b1, 32'd340, 32'd3,         1'b0, 32'd0,         16'd3);
    vecs[6] = mkVec(1'b0, 32'd84,  32'd0,         1'b1, 32'd3,         16'd3);
    vecs[7] = mkVec(1'b0, 32'd260, 32'd0,         1'b1, 32'h12345678,  16'd3);
    vecs[8] = mkVec(1'b1, 32'd8,   32'hCAFEF00D,  1'b0, 32'd0,         16'd4);
    vecs[9] = mkVec(1'b0, 32'd264, 32'd0,         1'b1, 32'hCAFEF00D,  16'd4);

    #22;
    resetA = 1'b1;
    checkFlagsA("reset", 1'b0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #2;
      if (vecs[i].chkRd) begin
        checkOutput($sformatf("vec%0d_rd", i), busA.readdata, vecs[i].expRd);
      end
      stepA();
      checkFlagsA($sformatf("vec%0d", i), vecs[i].expDone, vecs[i].expPass,
                  vecs[i].expTimeout, vecs[i].expCount);
    end

    // Asynchronous reset mid-cycle: flags and count clear at once, RAM survives.
    applyStimulus(1'b0, 32'd84, 32'd0);
    #2;
    resetA = 1'b0;
    #1;
    checkFlagsA("midReset", 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("midReset_rd", busA.readdata, 32'd3);
    resetA = 1'b1;

    // PASS: mailbox receives EXPECT after some idle cycles; later stores are frozen out.
    repeat (8) stepA();
    checkFlagsA("prePass", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b1, 32'd84, 32'd7);
    stepA();
    checkFlagsA("pass", 1'b1, 1'b1, 1'b0, 16'd1);
    checkOutput("pass_rd84", busA.readdata, 32'd7);
    applyStimulus(1'b1, 32'd0, 32'd9);
    stepA();
    checkFlagsA("passFrozen", 1'b1, 1'b1, 1'b0, 16'd1);
    checkOutput("passFrozen_rd0", busA.readdata, 32'd5);

    // FAIL: wrong value, then a correct mailbox store and a RAM store are both ignored.
    pulseResetA();
    applyStimulus(1'b1, 32'd84, 32'd6);
    stepA();
    checkFlagsA("fail", 1'b1, 1'b0, 1'b0, 16'd1);
    applyStimulus(1'b1, 32'd84, 32'd7);
    stepA();
    checkFlagsA("failRetry", 1'b1, 1'b0, 1'b0, 16'd1);
    checkOutput("failRetry_rd84", busA.readdata, 32'd6);
    applyStimulus(1'b1, 32'd0, 32'd9);
    stepA();
    checkOutput("failFrozen_rd0", busA.readdata, 32'd5);

    // Upper bits of writedata take part in the EXPECT comparison.
    pulseResetA();
    applyStimulus(1'b1, 32'd84, 32'h00010007);
    stepA();
    checkFlagsA("wideFail", 1'b1, 1'b0, 1'b0, 16'd1);
    checkOutput("wideFail_rd84", busA.readdata, 32'h00010007);

    // Short-timeout instance: verdict exactly 20 edges after release.
    resetB = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    checkFlagsB("toEdge19", 1'b0, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    checkFlagsB("toEdge20", 1'b1, 1'b0, 1'b1, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkFlagsB("toHold", 1'b1, 1'b0, 1'b1, 16'd0);

    // Mailbox store in the cycle the counter reaches 19 beats the timeout.
    resetB = 1'b0;
    #1;
    checkFlagsB("toReset", 1'b0, 1'b0, 1'b0, 16'd0);
    resetB = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    busB.memwrite  = 1'b1;
    busB.dataaddr  = 32'd84;
    busB.writedata = 32'd7;
    @(posedge clk);
    #1;
    busB.memwrite = 1'b0;
    checkFlagsB("raceMailbox", 1'b1, 1'b1, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
